// File: rtl/dc_bsp_pkg.sv
// Shared BSP definitions: kernel-side bus widths, arbiter defaults and state type.
package dc_bsp_pkg;

    localparam int OPENCL_QSYS_ADDR_WIDTH             = 32;
    localparam int OPENCL_BSP_KERNEL_DATA_WIDTH       = 32;
    localparam int OPENCL_BSP_KERNEL_BURSTCOUNT_WIDTH = 5;
    localparam int OPENCL_BSP_KERNEL_BYTEENABLE_WIDTH = 4;

    localparam int KMEM_ARB_RD_TAG_DEPTH = 16;
    localparam int KMEM_ARB_WR_TAG_DEPTH = 16;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        CMD    = 2'd1,
        WBURST = 2'd2
    } arb_state_e;

endpackage

// File: rtl/kernel_mem_arb_tag_fifo.sv
// Small tag FIFO with registered pointers; DEPTH must be a power of two (>= 2).
module kernel_mem_arb_tag_fifo
    import dc_bsp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = KMEM_ARB_RD_TAG_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Status flags and pointer/count updates; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head     = mem_q[rd_ptr_q];
    end

    // Tag storage; contents need no reset because empty guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/kernel_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM burst memory port among NUM_REQ kernel masters.
// Read and write tags are queued so responses route back in issue order.
module kernel_mem_arbiter
    import dc_bsp_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int ADDR_WIDTH       = OPENCL_QSYS_ADDR_WIDTH,
    parameter int DATA_WIDTH       = OPENCL_BSP_KERNEL_DATA_WIDTH,
    parameter int BURSTCOUNT_WIDTH = OPENCL_BSP_KERNEL_BURSTCOUNT_WIDTH,
    parameter int BYTEENABLE_WIDTH = OPENCL_BSP_KERNEL_BYTEENABLE_WIDTH,
    parameter int RD_TAG_DEPTH     = KMEM_ARB_RD_TAG_DEPTH,
    parameter int WR_TAG_DEPTH     = KMEM_ARB_WR_TAG_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    ker_read,
    input  logic [NUM_REQ-1:0]                    ker_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         ker_address,
    input  logic [NUM_REQ*BURSTCOUNT_WIDTH-1:0]   ker_burstcount,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         ker_writedata,
    input  logic [NUM_REQ*BYTEENABLE_WIDTH-1:0]   ker_byteenable,
    output logic [NUM_REQ-1:0]                    ker_waitrequest,
    output logic [DATA_WIDTH-1:0]                 ker_readdata,
    output logic [NUM_REQ-1:0]                    ker_readdatavalid,
    output logic [NUM_REQ-1:0]                    ker_writeack,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic [ADDR_WIDTH-1:0]                 mem_address,
    output logic [BURSTCOUNT_WIDTH-1:0]           mem_burstcount,
    output logic [DATA_WIDTH-1:0]                 mem_writedata,
    output logic [BYTEENABLE_WIDTH-1:0]           mem_byteenable,
    input  logic                                  mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]                 mem_readdata,
    input  logic                                  mem_readdatavalid,
    input  logic                                  mem_writeack,
    output logic                                  rsp_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BW    = BURSTCOUNT_WIDTH;
    localparam int RD_W  = IDX_W + BW;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]    wbeats_q, wbeats_d;
    logic [BW-1:0]    rbeat_q, rbeat_d;
    logic             rsp_err_q, rsp_err_d;

    logic                  sel_read, sel_write;
    logic [BW-1:0]         sel_bc;
    logic [NUM_REQ-1:0]    elig;
    logic [IDX_W:0]        pick;
    logic                  rd_push, rd_pop, rd_full, rd_empty;
    logic                  wr_push, wr_pop, wr_full, wr_empty;
    logic [RD_W-1:0]       rd_head;
    logic [IDX_W-1:0]      wr_head;

    // First eligible requester at or after ptr; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        return (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
    endfunction

    kernel_mem_arb_tag_fifo #(.WIDTH(RD_W), .DEPTH(RD_TAG_DEPTH)) u_rd_tags (
        .clk(clk), .reset(reset), .push(rd_push), .push_data({gnt_q, sel_bc}),
        .pop(rd_pop), .head(rd_head), .full(rd_full), .empty(rd_empty)
    );

    kernel_mem_arb_tag_fifo #(.WIDTH(IDX_W), .DEPTH(WR_TAG_DEPTH)) u_wr_tags (
        .clk(clk), .reset(reset), .push(wr_push), .push_data(gnt_q),
        .pop(wr_pop), .head(wr_head), .full(wr_full), .empty(wr_empty)
    );

    // Command mux: the granted requester's bus is presented to memory.
    always_comb begin
        sel_read       = ker_read[gnt_q];
        sel_write      = ker_write[gnt_q];
        sel_bc         = ker_burstcount[int'(gnt_q)*BW +: BW];
        mem_address    = ker_address[int'(gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_burstcount = sel_bc;
        mem_writedata  = ker_writedata[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
        mem_byteenable = ker_byteenable[int'(gnt_q)*BYTEENABLE_WIDTH +: BYTEENABLE_WIDTH];
        ker_readdata   = mem_readdata;
    end

    // Arbitration FSM, tag pushes, response routing and error flag.
    always_comb begin
        state_d           = state_q;
        gnt_d             = gnt_q;
        rr_ptr_d          = rr_ptr_q;
        wbeats_d          = wbeats_q;
        rbeat_d           = rbeat_q;
        rsp_err_d         = rsp_err_q;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        ker_waitrequest   = '1;
        ker_readdatavalid = '0;
        ker_writeack      = '0;
        rd_push           = 1'b0;
        wr_push           = 1'b0;
        rd_pop            = 1'b0;
        wr_pop            = 1'b0;
        elig              = (ker_read & {NUM_REQ{~rd_full}}) | (ker_write & {NUM_REQ{~wr_full}});
        pick              = rr_pick(elig, rr_ptr_q);

        case (state_q)
            ARB: begin
                if (pick[IDX_W]) begin
                    gnt_d   = pick[IDX_W-1:0];
                    state_d = CMD;
                end
            end
            CMD: begin
                mem_write = sel_write & ~wr_full;
                mem_read  = sel_read & ~sel_write & ~rd_full;
                ker_waitrequest[gnt_q] = mem_waitrequest | ~(mem_read | mem_write);
                if (!sel_read && !sel_write) begin
                    state_d = ARB;
                end else if (mem_read && !mem_waitrequest) begin
                    rd_push  = 1'b1;
                    rr_ptr_d = next_idx(gnt_q);
                    state_d  = ARB;
                end else if (mem_write && !mem_waitrequest) begin
                    wr_push  = 1'b1;
                    wbeats_d = sel_bc - 1'b1;
                    if (sel_bc <= BW'(1)) begin
                        wbeats_d = '0;
                        rr_ptr_d = next_idx(gnt_q);
                        state_d  = ARB;
                    end else begin
                        state_d  = WBURST;
                    end
                end
            end
            WBURST: begin
                // Grant is locked; reads from this requester stay stalled until the burst ends.
                mem_write = sel_write;
                ker_waitrequest[gnt_q] = mem_waitrequest | ~sel_write;
                if (sel_write && !mem_waitrequest) begin
                    wbeats_d = wbeats_q - 1'b1;
                    if (wbeats_q == BW'(1)) begin
                        rr_ptr_d = next_idx(gnt_q);
                        state_d  = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase

        if (mem_readdatavalid) begin
            if (rd_empty) begin
                rsp_err_d = 1'b1;
            end else begin
                ker_readdatavalid[rd_head[RD_W-1 -: IDX_W]] = 1'b1;
                if (({1'b0, rbeat_q} + 1'b1) >= {1'b0, rd_head[BW-1:0]}) begin
                    rd_pop  = 1'b1;
                    rbeat_d = '0;
                end else begin
                    rbeat_d = rbeat_q + 1'b1;
                end
            end
        end

        if (mem_writeack) begin
            if (wr_empty) begin
                rsp_err_d = 1'b1;
            end else begin
                ker_writeack[wr_head] = 1'b1;
                wr_pop = 1'b1;
            end
        end

        // While reset is held, present an idle port regardless of stale state.
        if (reset) begin
            mem_read          = 1'b0;
            mem_write         = 1'b0;
            ker_waitrequest   = '1;
            ker_readdatavalid = '0;
            ker_writeack      = '0;
            rd_push           = 1'b0;
            wr_push           = 1'b0;
            rd_pop            = 1'b0;
            wr_pop            = 1'b0;
        end
        rsp_err = rsp_err_q;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            wbeats_q  <= '0;
            rbeat_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            wbeats_q  <= wbeats_d;
            rbeat_q   <= rbeat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_kernel_mem_arbiter.sv
// Bench for kernel_mem_arbiter: requester models, a memory model and response scoreboards.
module tb_kernel_mem_arbiter;
    import dc_bsp_pkg::*;

    localparam int NR  = 4;
    localparam int AW  = OPENCL_QSYS_ADDR_WIDTH;
    localparam int DW  = OPENCL_BSP_KERNEL_DATA_WIDTH;
    localparam int BW  = OPENCL_BSP_KERNEL_BURSTCOUNT_WIDTH;
    localparam int BEW = OPENCL_BSP_KERNEL_BYTEENABLE_WIDTH;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     ker_read = '0, ker_write = '0;
    logic [NR*AW-1:0]  ker_address = '0;
    logic [NR*BW-1:0]  ker_burstcount = '0;
    logic [NR*DW-1:0]  ker_writedata = '0;
    logic [NR*BEW-1:0] ker_byteenable = '0;
    logic [NR-1:0]     ker_waitrequest, ker_readdatavalid, ker_writeack;
    logic [DW-1:0]     ker_readdata;
    logic              mem_read, mem_write;
    logic [AW-1:0]     mem_address;
    logic [BW-1:0]     mem_burstcount;
    logic [DW-1:0]     mem_writedata;
    logic [BEW-1:0]    mem_byteenable;
    logic              mem_waitrequest = 1'b0;
    logic [DW-1:0]     mem_readdata = '0;
    logic              mem_readdatavalid = 1'b0;
    logic              mem_writeack = 1'b0;
    logic              rsp_err;

    kernel_mem_arbiter #(.NUM_REQ(NR), .RD_TAG_DEPTH(4), .WR_TAG_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .ker_read(ker_read), .ker_write(ker_write), .ker_address(ker_address),
        .ker_burstcount(ker_burstcount), .ker_writedata(ker_writedata),
        .ker_byteenable(ker_byteenable), .ker_waitrequest(ker_waitrequest),
        .ker_readdata(ker_readdata), .ker_readdatavalid(ker_readdatavalid),
        .ker_writeack(ker_writeack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_burstcount(mem_burstcount), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .mem_writeack(mem_writeack), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; int addr; int bc; } cmd_t;
    typedef struct { int r; int data; } rsp_t;
    typedef struct { logic [15:0] nrd; logic [31:0] gseq; int ng; } vec_t;

    cmd_t rq[NR][$];
    int   wbeat[NR];
    rsp_t exp_rd[$];
    int   exp_wa[$];
    cmd_t mrd[$];
    int   glog[$];
    int   mrd_beat, mwr_left, ack_cnt;
    int   n_rd_acc, n_wr_beats;
    bit   mem_hold, mem_stall, stray_rdv, rst_drive = 1'b1;
    int   tests, fails;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit busy();
        bit b = (mrd.size() != 0) || (ack_cnt != 0) || (exp_rd.size() != 0) || (exp_wa.size() != 0);
        for (int r = 0; r < NR; r++) if (rq[r].size() != 0) b = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] seq_from(input int base);
        logic [31:0] s = '0;
        for (int k = 0; k < 8 && base + k < glog.size(); k++) s[k*4 +: 4] = 4'(glog[base + k]);
        return s;
    endfunction

    // One clock: drive at negedge, sample 1ns later, then advance the models.
    task automatic step();
        cmd_t h, m;
        rsp_t e;
        int   nacc, ar, ack_new;
        bit   macc;
        @(negedge clk);
        reset = rst_drive;
        for (int r = 0; r < NR; r++) begin
            ker_read[r] = 1'b0;
            ker_write[r] = 1'b0;
            ker_address[r*AW +: AW] = '0;
            ker_burstcount[r*BW +: BW] = '0;
            ker_writedata[r*DW +: DW] = '0;
            ker_byteenable[r*BEW +: BEW] = BEW'(r + 1);
            if (rq[r].size() != 0) begin
                h = rq[r][0];
                ker_read[r] = !h.wr;
                ker_write[r] = h.wr;
                ker_address[r*AW +: AW] = AW'(h.addr);
                ker_burstcount[r*BW +: BW] = BW'(h.bc);
                ker_writedata[r*DW +: DW] = DW'(h.addr * 16 + wbeat[r]);
            end
        end
        mem_waitrequest = mem_stall;
        mem_readdatavalid = 1'b0;
        mem_readdata = '0;
        if (stray_rdv) begin
            mem_readdatavalid = 1'b1;
        end else if (!mem_hold && mrd.size() != 0) begin
            mem_readdatavalid = 1'b1;
            mem_readdata = DW'(mrd[0].addr * 16 + mrd_beat);
        end
        mem_writeack = (ack_cnt > 0);
        #1;
        if (mem_readdatavalid) begin
            if (exp_rd.size() != 0) begin
                e = exp_rd.pop_front();
                chk("rdv_onehot", ker_readdatavalid, 1 << e.r);
                chk("readdata", ker_readdata, DW'(e.data));
            end else begin
                chk("stray_rdv", ker_readdatavalid, 0);
            end
        end else if (ker_readdatavalid != 0) begin
            chk("spurious_rdv", ker_readdatavalid, 0);
        end
        if (mem_writeack) begin
            if (exp_wa.size() != 0) chk("writeack_onehot", ker_writeack, 1 << exp_wa.pop_front());
            else chk("stray_wack", ker_writeack, 0);
        end else if (ker_writeack != 0) begin
            chk("spurious_wack", ker_writeack, 0);
        end
        nacc = 0;
        ar = 0;
        for (int r = 0; r < NR; r++)
            if ((ker_read[r] | ker_write[r]) && !ker_waitrequest[r]) begin nacc++; ar = r; end
        macc = (mem_read | mem_write) && !mem_waitrequest;
        ack_new = 0;
        if (nacc != 0 || macc) begin
            chk("req_side_accepts", nacc, 1);
            chk("mem_side_accept", macc, 1);
        end
        if (nacc == 1 && macc) begin
            h = rq[ar][0];
            glog.push_back(ar);
            chk("mem_address", mem_address, AW'(h.addr));
            chk("mem_burstcount", mem_burstcount, BW'(h.bc));
            chk("mem_byteenable", mem_byteenable, BEW'(ar + 1));
            if (!h.wr) begin
                chk("mem_read", {mem_read, mem_write}, 2'b10);
                for (int b = 0; b < h.bc; b++) begin
                    e.r = ar;
                    e.data = h.addr * 16 + b;
                    exp_rd.push_back(e);
                end
                m.wr = 1'b0;
                m.addr = int'(mem_address);
                m.bc = int'(mem_burstcount);
                mrd.push_back(m);
                n_rd_acc++;
                void'(rq[ar].pop_front());
            end else begin
                chk("mem_write", {mem_read, mem_write}, 2'b01);
                chk("mem_writedata", mem_writedata, DW'(h.addr * 16 + wbeat[ar]));
                if (wbeat[ar] == 0) exp_wa.push_back(ar);
                if (mwr_left == 0) mwr_left = int'(mem_burstcount);
                mwr_left--;
                if (mwr_left == 0) ack_new = 1;
                n_wr_beats++;
                wbeat[ar]++;
                if (wbeat[ar] == h.bc) begin
                    wbeat[ar] = 0;
                    void'(rq[ar].pop_front());
                end
            end
        end
        if (mem_readdatavalid && !stray_rdv) begin
            mrd_beat++;
            if (mrd_beat == mrd[0].bc) begin
                mrd_beat = 0;
                void'(mrd.pop_front());
            end
        end
        if (mem_writeack) ack_cnt--;
        ack_cnt += ack_new;
    endtask

    task automatic run_idle(input string name, input int max);
        int n = 0;
        while (busy() && n < max) begin step(); n++; end
        chk({name, "_drained"}, busy(), 0);
    endtask

    task automatic wait_rd(input int target, input string name);
        int n = 0;
        while (n_rd_acc < target && n < 50) begin step(); n++; end
        chk(name, n_rd_acc, target);
    endtask

    task automatic wait_wr(input int target, input string name);
        int n = 0;
        while (n_wr_beats < target && n < 50) begin step(); n++; end
        chk(name, n_wr_beats, target);
    endtask

    function automatic cmd_t mk(input bit wr, input int addr, input int bc);
        cmd_t c;
        c.wr = wr;
        c.addr = addr;
        c.bc = bc;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   base, start;

        // nrd nibble r = reads from requester r; gseq nibble k = k-th grant.
        vt[0].nrd = 16'h1112; vt[0].gseq = 32'h00003210; vt[0].ng = 5;
        vt[1].nrd = 16'h0101; vt[1].gseq = 32'h00000002; vt[1].ng = 2;
        vt[2].nrd = 16'h1010; vt[2].gseq = 32'h00000031; vt[2].ng = 2;
        vt[3].nrd = 16'h1100; vt[3].gseq = 32'h00000032; vt[3].ng = 2;
        vt[4].nrd = 16'h1003; vt[4].gseq = 32'h00000030; vt[4].ng = 4;
        vt[5].nrd = 16'h0220; vt[5].gseq = 32'h00002121; vt[5].ng = 4;
        vt[6].nrd = 16'h2001; vt[6].gseq = 32'h00000303; vt[6].ng = 3;

        for (int i = 0; i < 3; i++) step();
        chk("rst_waitreq", ker_waitrequest, 4'hF);
        chk("rst_mem_cmd", {mem_read, mem_write}, 2'b00);
        chk("rst_rdv", ker_readdatavalid, 0);
        chk("rst_wack", ker_writeack, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_drive = 1'b0;
        step();

        // Round-robin fairness table with single-beat reads.
        for (int v = 0; v < 7; v++) begin
            base = glog.size();
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < int'(vt[v].nrd[r*4 +: 4]); k++)
                    rq[r].push_back(mk(1'b0, r * 256 + v * 16 + k, 1));
            run_idle("table", 200);
            chk("grant_order", seq_from(base), vt[v].gseq);
            chk("grant_count", glog.size() - base, vt[v].ng);
        end

        // Write burst holds the grant against a competing read.
        rq[0].push_back(mk(1'b0, 'h0F00, 1));
        run_idle("wlock_prep", 50);
        base = glog.size();
        rq[1].push_back(mk(1'b1, 'h1000, 4));
        rq[0].push_back(mk(1'b0, 'h2000, 1));
        run_idle("wlock", 100);
        chk("wlock_order", seq_from(base), 32'h00001111 | (32'h0 << 16));
        chk("wlock_count", glog.size() - base, 5);

        // Interleaved multi-beat read returns.
        mem_hold = 1'b1;
        base = glog.size();
        start = n_rd_acc;
        rq[2].push_back(mk(1'b0, 'h3000, 3));
        wait_rd(start + 1, "ilv_req2_acc");
        rq[0].push_back(mk(1'b0, 'h3100, 2));
        wait_rd(start + 2, "ilv_req0_acc");
        mem_hold = 1'b0;
        run_idle("ilv", 100);
        chk("ilv_order", seq_from(base), 32'h00000002);

        // Read tag FIFO full: only four reads outstanding while memory withholds data.
        mem_hold = 1'b1;
        start = n_rd_acc;
        rq[0].push_back(mk(1'b0, 'h6000, 1)); rq[0].push_back(mk(1'b0, 'h6001, 1));
        rq[1].push_back(mk(1'b0, 'h6100, 1)); rq[1].push_back(mk(1'b0, 'h6101, 1));
        rq[2].push_back(mk(1'b0, 'h6200, 1));
        rq[3].push_back(mk(1'b0, 'h6300, 1));
        for (int i = 0; i < 20; i++) step();
        chk("tagfull_accepted", n_rd_acc - start, 4);
        chk("tagfull_waitreq", ker_waitrequest, 4'hF);
        chk("tagfull_no_read", mem_read, 0);
        mem_hold = 1'b0;
        run_idle("tagfull", 200);
        chk("tagfull_total", n_rd_acc - start, 6);

        // Memory backpressure in the middle of a write burst.
        base = glog.size();
        start = n_wr_beats;
        rq[3].push_back(mk(1'b1, 'h4000, 4));
        wait_wr(start + 1, "bp_first_beat");
        rq[0].push_back(mk(1'b0, 'h4100, 1));
        wait_wr(start + 2, "bp_second_beat");
        mem_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold", {ker_waitrequest[3], ker_waitrequest[0], mem_write, mem_read}, 4'b1110);
            chk("bp_data", mem_writedata, DW'('h4000 * 16 + 2));
        end
        mem_stall = 1'b0;
        run_idle("bp", 100);
        chk("bp_order", seq_from(base), 32'h00003333);
        chk("bp_beats", n_wr_beats - start, 4);
        chk("no_err_before_reset", rsp_err, 0);

        // Reset in the middle of a write burst, then a stray read response.
        start = n_wr_beats;
        rq[1].push_back(mk(1'b1, 'h5000, 4));
        wait_wr(start + 2, "rst_mid_beats");
        rst_drive = 1'b1;
        exp_rd.delete(); exp_wa.delete(); mrd.delete();
        mrd_beat = 0; mwr_left = 0; ack_cnt = 0;
        step();
        chk("midrst_waitreq", ker_waitrequest, 4'hF);
        chk("midrst_mem_cmd", {mem_read, mem_write}, 2'b00);
        chk("midrst_pulses", {ker_readdatavalid, ker_writeack}, 0);
        for (int r = 0; r < NR; r++) begin rq[r].delete(); wbeat[r] = 0; end
        step();
        rst_drive = 1'b0;
        step();
        chk("midrst_rsp_err", rsp_err, 0);
        stray_rdv = 1'b1;
        step();
        stray_rdv = 1'b0;
        step();
        chk("stray_rsp_err", rsp_err, 1);
        chk("stray_idle_waitreq", ker_waitrequest, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
